// File: rtl/pc060ha_mailbox_file.sv
// pc060ha_mailbox_file
//   Nibble-wide mailbox array between the master (68000) and slave (Z80)
//   ports of the PC060HA. Each side's asynchronous strobes are synchronised
//   and edge-detected. The page is latched at cycle start, and writes and
//   read side effects commit at cycle end.
// Ports
//   CLK, RESET                 clock, synchronous active-high reset
//   M_nCS/M_nRD/M_nWR          master strobes, active low, async
//   M_PAGE[2:0], M_DIN[3:0]    master page register value / write data
//   M_DOUT[3:0]                master read data (registered)
//   S_nCS/S_nRD/S_nWR          slave strobes, active low, async
//   S_PAGE[2:0], S_DIN[3:0]    slave page register value / write data
//   S_DOUT[3:0]                slave read data (registered)
//   S_NMI                      slave NMI request, level, registered
//   S_RESET_OUT                slave CPU reset request, registered

// Per-side strobe synchroniser, edge detector and page/data latches.
module pc060ha_mailbox_port #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       n_cs,
  input  logic       n_rd,
  input  logic       n_wr,
  input  logic [2:0] page,
  input  logic [3:0] din,
  output logic       rd_on_c,
  output logic       rd_end_c,
  output logic       wr_end_c,
  output logic [2:0] page_sel_c,
  output logic [2:0] page_l,
  output logic [3:0] din_l
);
  localparam int unsigned CW = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] rd_sync;
  logic [SYNC_STAGES-1:0] wr_sync;
  logic                   rd_s;
  logic                   wr_s;
  logic                   rd_eff;
  logic                   rd_q;
  logic                   wr_q;
  logic                   armed;
  logic [CW-1:0]          fill;
  logic                   start_c;

  assign rd_s   = rd_sync[SYNC_STAGES-1];
  assign wr_s   = wr_sync[SYNC_STAGES-1];
  // A simultaneous write wins; the read is ignored.
  assign rd_eff = rd_s & ~wr_s;

  assign start_c    = armed & ((rd_eff & ~rd_q) | (wr_s & ~wr_q));
  assign rd_on_c    = armed & rd_eff;
  assign rd_end_c   = armed & rd_q & ~rd_s & ~wr_s;
  assign wr_end_c   = armed & wr_q & ~wr_s;
  // Use the live page on the start cycle so DOUT is valid one clock later.
  assign page_sel_c = start_c ? page : page_l;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_sync <= '0;
      wr_sync <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      armed   <= 1'b0;
      fill    <= '0;
      page_l  <= 3'd0;
      din_l   <= 4'd0;
    end else begin
      rd_sync <= {rd_sync[SYNC_STAGES-2:0], ~n_cs & ~n_rd};
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], ~n_cs & ~n_wr};
      rd_q    <= rd_eff;
      wr_q    <= wr_s;
      // Arm only once the chain holds real samples and both strobes are idle,
      // so a strobe held across reset release never produces an end event.
      if (fill != CW'(SYNC_STAGES)) begin
        fill <= fill + CW'(1);
      end else if (!rd_s && !wr_s) begin
        armed <= 1'b1;
      end
      if (start_c) page_l <= page;
      if (wr_s)    din_l  <= din;
    end
  end
endmodule

// Mailbox registers, full flags, NMI and slave reset control.
module pc060ha_mailbox_file #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       M_nCS,
  input  logic       M_nRD,
  input  logic       M_nWR,
  input  logic [2:0] M_PAGE,
  input  logic [3:0] M_DIN,
  output logic [3:0] M_DOUT,
  input  logic       S_nCS,
  input  logic       S_nRD,
  input  logic       S_nWR,
  input  logic [2:0] S_PAGE,
  input  logic [3:0] S_DIN,
  output logic [3:0] S_DOUT,
  output logic       S_NMI,
  output logic       S_RESET_OUT
);
  logic       m_rd_on, m_rd_end, m_wr_end;
  logic       s_rd_on, s_rd_end, s_wr_end;
  logic [2:0] m_sel, m_page_l, s_sel, s_page_l;
  logic [3:0] m_din_l, s_din_l;

  logic [3:0][3:0] m2s;
  logic [3:0][3:0] s2m;
  logic [1:0]      m2s_full, s2m_full;
  logic [1:0]      m2s_full_nxt, s2m_full_nxt;
  logic [1:0]      m2s_set, m2s_clr, s2m_set, s2m_clr;
  logic            nmi_en;
  logic [3:0]      m_mux, s_mux;

  pc060ha_mailbox_port #(.SYNC_STAGES(SYNC_STAGES)) u_master (
    .clk        (CLK),
    .reset      (RESET),
    .n_cs       (M_nCS),
    .n_rd       (M_nRD),
    .n_wr       (M_nWR),
    .page       (M_PAGE),
    .din        (M_DIN),
    .rd_on_c    (m_rd_on),
    .rd_end_c   (m_rd_end),
    .wr_end_c   (m_wr_end),
    .page_sel_c (m_sel),
    .page_l     (m_page_l),
    .din_l      (m_din_l)
  );

  pc060ha_mailbox_port #(.SYNC_STAGES(SYNC_STAGES)) u_slave (
    .clk        (CLK),
    .reset      (RESET),
    .n_cs       (S_nCS),
    .n_rd       (S_nRD),
    .n_wr       (S_nWR),
    .page       (S_PAGE),
    .din        (S_DIN),
    .rd_on_c    (s_rd_on),
    .rd_end_c   (s_rd_end),
    .wr_end_c   (s_wr_end),
    .page_sel_c (s_sel),
    .page_l     (s_page_l),
    .din_l      (s_din_l)
  );

  // Read data muxes.
  always_comb begin
    m_mux = 4'hF;
    s_mux = 4'hF;
    case (m_sel)
      3'd0, 3'd1, 3'd2, 3'd3: m_mux = s2m[m_sel[1:0]];
      3'd4:                   m_mux = {m2s_full, s2m_full};
      default:                m_mux = 4'hF;
    endcase
    case (s_sel)
      3'd0, 3'd1, 3'd2, 3'd3: s_mux = m2s[s_sel[1:0]];
      3'd4:                   s_mux = {s2m_full, m2s_full};
      default:                s_mux = 4'hF;
    endcase
  end

  // Full flags: writer's end sets, reader's end clears; set wins.
  always_comb begin
    m2s_set      = {m_wr_end && (m_page_l == 3'd3), m_wr_end && (m_page_l == 3'd1)};
    m2s_clr      = {s_rd_end && (s_page_l == 3'd3), s_rd_end && (s_page_l == 3'd1)};
    s2m_set      = {s_wr_end && (s_page_l == 3'd3), s_wr_end && (s_page_l == 3'd1)};
    s2m_clr      = {m_rd_end && (m_page_l == 3'd3), m_rd_end && (m_page_l == 3'd1)};
    m2s_full_nxt = (m2s_full & ~m2s_clr) | m2s_set;
    s2m_full_nxt = (s2m_full & ~s2m_clr) | s2m_set;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      m2s         <= '0;
      s2m         <= '0;
      m2s_full    <= 2'b00;
      s2m_full    <= 2'b00;
      nmi_en      <= 1'b0;
      S_NMI       <= 1'b0;
      S_RESET_OUT <= 1'b0;
      M_DOUT      <= 4'd0;
      S_DOUT      <= 4'd0;
    end else begin
      if (m_wr_end && !m_page_l[2]) m2s[m_page_l[1:0]] <= m_din_l;
      if (s_wr_end && !s_page_l[2]) s2m[s_page_l[1:0]] <= s_din_l;
      if (m_wr_end && (m_page_l == 3'd4)) S_RESET_OUT <= m_din_l[0];
      if (s_wr_end && (s_page_l == 3'd5)) nmi_en <= 1'b0;
      if (s_wr_end && (s_page_l == 3'd6)) nmi_en <= 1'b1;
      m2s_full <= m2s_full_nxt;
      s2m_full <= s2m_full_nxt;
      // Registered from current flag/enable state: one clock behind a change.
      S_NMI    <= nmi_en & (m2s_full[0] | m2s_full[1]);
      if (m_rd_on) M_DOUT <= m_mux;
      if (s_rd_on) S_DOUT <= s_mux;
    end
  end
endmodule

// File: tb/tb_pc060ha_mailbox_file.sv
// tb_pc060ha_mailbox_file
//   Directed bench for pc060ha_mailbox_file: master/slave mailbox traffic,
//   full flags, NMI gating, page change at strobe end, simultaneous events,
//   reset with a held strobe, and slave reset / unmapped page reads.
module tb_pc060ha_mailbox_file;
  logic       CLK = 1'b0;
  logic       RESET;
  logic       M_nCS, M_nRD, M_nWR;
  logic [2:0] M_PAGE;
  logic [3:0] M_DIN;
  logic [3:0] M_DOUT;
  logic       S_nCS, S_nRD, S_nWR;
  logic [2:0] S_PAGE;
  logic [3:0] S_DIN;
  logic [3:0] S_DOUT;
  logic       S_NMI;
  logic       S_RESET_OUT;

  int checks   = 0;
  int failures = 0;
  logic [3:0] rd;

  pc060ha_mailbox_file #(.SYNC_STAGES(2)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .M_nCS       (M_nCS),
    .M_nRD       (M_nRD),
    .M_nWR       (M_nWR),
    .M_PAGE      (M_PAGE),
    .M_DIN       (M_DIN),
    .M_DOUT      (M_DOUT),
    .S_nCS       (S_nCS),
    .S_nRD       (S_nRD),
    .S_nWR       (S_nWR),
    .S_PAGE      (S_PAGE),
    .S_DIN       (S_DIN),
    .S_DOUT      (S_DOUT),
    .S_NMI       (S_NMI),
    .S_RESET_OUT (S_RESET_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_write(input logic [2:0] p, input logic [3:0] d);
    @(negedge CLK);
    M_PAGE = p; M_DIN = d; M_nCS = 1'b0; M_nWR = 1'b0;
    repeat (4) @(negedge CLK);
    M_nWR = 1'b1; M_nCS = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  task automatic m_read(input logic [2:0] p, output logic [3:0] d);
    @(negedge CLK);
    M_PAGE = p; M_nCS = 1'b0; M_nRD = 1'b0;
    repeat (4) @(negedge CLK);
    d = M_DOUT;
    M_nRD = 1'b1; M_nCS = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  task automatic s_write(input logic [2:0] p, input logic [3:0] d);
    @(negedge CLK);
    S_PAGE = p; S_DIN = d; S_nCS = 1'b0; S_nWR = 1'b0;
    repeat (4) @(negedge CLK);
    S_nWR = 1'b1; S_nCS = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  task automatic s_read(input logic [2:0] p, output logic [3:0] d);
    @(negedge CLK);
    S_PAGE = p; S_nCS = 1'b0; S_nRD = 1'b0;
    repeat (4) @(negedge CLK);
    d = S_DOUT;
    S_nRD = 1'b1; S_nCS = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  initial begin
    RESET = 1'b1;
    M_nCS = 1'b1; M_nRD = 1'b1; M_nWR = 1'b1; M_PAGE = 3'd0; M_DIN = 4'd0;
    S_nCS = 1'b1; S_nRD = 1'b1; S_nWR = 1'b1; S_PAGE = 3'd0; S_DIN = 4'd0;
    repeat (3) @(negedge CLK);
    chk("rst_m_dout", M_DOUT, 4'h0);
    chk("rst_s_dout", S_DOUT, 4'h0);
    chk("rst_s_nmi", {3'b0, S_NMI}, 4'h0);
    chk("rst_s_reset_out", {3'b0, S_RESET_OUT}, 4'h0);
    RESET = 1'b0;
    repeat (6) @(negedge CLK);

    // 1: master fills pages 0,1; slave status shows m2s_full[0]
    m_write(3'd0, 4'h5);
    m_write(3'd1, 4'hA);
    s_read(3'd4, rd);
    chk("t1_s_status", rd, 4'b0001);
    chk("t1_nmi_disabled", {3'b0, S_NMI}, 4'h0);

    // 2: NMI enable, flag set, slave read clears it
    s_write(3'd6, 4'h0);
    m_write(3'd1, 4'h3);
    chk("t2_nmi_on", {3'b0, S_NMI}, 4'h1);
    s_read(3'd1, rd);
    chk("t2_s_rd1", rd, 4'h3);
    chk("t2_nmi_off", {3'b0, S_NMI}, 4'h0);
    s_read(3'd4, rd);
    chk("t2_s_status", rd, 4'b0000);

    // 3: page increments 1->2 exactly at strobe deassert
    @(negedge CLK);
    M_PAGE = 3'd1; M_DIN = 4'h6; M_nCS = 1'b0; M_nWR = 1'b0;
    repeat (4) @(negedge CLK);
    M_nWR = 1'b1; M_nCS = 1'b1; M_PAGE = 3'd2;
    repeat (5) @(negedge CLK);
    s_read(3'd1, rd);
    chk("t3_nibble1", rd, 4'h6);
    s_read(3'd2, rd);
    chk("t3_nibble2", rd, 4'h0);

    // 4: master write end and slave read end of page 3 on the same clock
    m_write(3'd3, 4'h7);
    s_read(3'd3, rd);
    chk("t4_prev", rd, 4'h7);
    @(negedge CLK);
    M_PAGE = 3'd3; M_DIN = 4'h9; M_nCS = 1'b0; M_nWR = 1'b0;
    S_PAGE = 3'd3; S_nCS = 1'b0; S_nRD = 1'b0;
    repeat (4) @(negedge CLK);
    M_nWR = 1'b1; M_nCS = 1'b1; S_nRD = 1'b1; S_nCS = 1'b1;
    repeat (5) @(negedge CLK);
    chk("t4_s_dout_old", S_DOUT, 4'h7);
    s_read(3'd4, rd);
    chk("t4_set_wins", rd, 4'b0010);
    s_read(3'd3, rd);
    chk("t4_new_data", rd, 4'h9);

    // slave-to-master direction
    s_write(3'd1, 4'hC);
    m_read(3'd4, rd);
    chk("s2m_status_set", rd, 4'b0001);
    m_read(3'd1, rd);
    chk("s2m_data", rd, 4'hC);
    m_read(3'd4, rd);
    chk("s2m_status_clr", rd, 4'b0000);

    // 5: reset pulse while master write strobe is held
    @(negedge CLK);
    M_PAGE = 3'd2; M_DIN = 4'hE; M_nCS = 1'b0; M_nWR = 1'b0;
    repeat (4) @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    repeat (6) @(negedge CLK);
    M_nWR = 1'b1; M_nCS = 1'b1;
    repeat (6) @(negedge CLK);
    s_read(3'd2, rd);
    chk("t5_no_commit", rd, 4'h0);
    s_read(3'd0, rd);
    chk("t5_cleared", rd, 4'h0);
    s_read(3'd4, rd);
    chk("t5_flags", rd, 4'b0000);
    m_write(3'd2, 4'hB);
    s_read(3'd2, rd);
    chk("t5_recover", rd, 4'hB);

    // 6: slave reset control and unmapped page read
    m_write(3'd4, 4'h1);
    chk("t6_sreset_on", {3'b0, S_RESET_OUT}, 4'h1);
    m_write(3'd4, 4'h0);
    chk("t6_sreset_off", {3'b0, S_RESET_OUT}, 4'h0);
    m_read(3'd6, rd);
    chk("t6_m_page6", rd, 4'hF);

    // NMI disable via slave page 5 with the flag still set
    m_write(3'd1, 4'h2);
    s_write(3'd6, 4'h0);
    chk("nmi_en_on", {3'b0, S_NMI}, 4'h1);
    s_write(3'd5, 4'h0);
    chk("nmi_en_off", {3'b0, S_NMI}, 4'h0);
    s_read(3'd7, rd);
    chk("s_page7", rd, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
